// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: paints a NUM_ROWS x NUM_COLS text frame onto an HD44780-class
// character LCD over the 4-bit write-only bus, with a start/busy/done handshake
// and an optional continuous-refresh mode.
module lcd_frame_writer #(
  parameter int CLK_DIV    = 1000000,
  parameter int NUM_COLS   = 16,
  parameter int NUM_ROWS   = 2,
  parameter int CLEAR_WAIT = 2,
  parameter int CONTINUOUS = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*NUM_COLS-1:0] line1,
  input  logic [8*NUM_COLS-1:0] line2,
  output logic                  busy,
  output logic                  done,
  output logic                  lcd_rs,
  output logic                  lcd_w,
  output logic                  lcd_e,
  output logic [3:0]            data
);

  localparam int               DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]       INIT_LAST = 7'd11;
  localparam logic [6:0]       ADDR_LAST = 7'd1;
  localparam logic [6:0]       ROW_LAST  = 7'(2 * NUM_COLS - 1);
  localparam logic [15:0]      WAIT_LAST = 16'(CLEAR_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, INIT, CLR_WAIT, ADDR1, ROW1, ADDR2, ROW2, FIN
  } state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic                  accept;
  logic [1:0]            phase;
  logic [6:0]            nib_idx;
  logic [15:0]           wait_cnt;
  logic                  init_done;
  logic [8*NUM_COLS-1:0] row1_buf;
  logic [8*NUM_COLS-1:0] row2_buf;
  logic [8*NUM_COLS-1:0] row_shift;
  logic [7:0]            ch;
  logic [3:0]            cur_nib;
  logic                  cur_rs;
  logic                  nib_last;

  assign lcd_w  = 1'b0;
  assign tick   = (div_cnt == DIV_LAST);
  assign accept = start && !busy && ((state == IDLE) || (state == FIN));

  // Tick divider: free-running, realigned to zero whenever a frame is accepted
  always_ff @(posedge clk) begin
    if (reset || accept || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Selects the nibble and register-select for the current position in the frame
  always_comb begin
    row_shift = '0;
    ch        = 8'h00;
    cur_nib   = 4'h0;
    cur_rs    = 1'b0;
    nib_last  = 1'b0;
    case (state)
      INIT: begin
        case (nib_idx[3:0])
          4'd0, 4'd1, 4'd2: cur_nib = 4'h3;
          4'd3, 4'd4:       cur_nib = 4'h2;
          4'd5:             cur_nib = 4'h8;
          4'd7:             cur_nib = 4'hC;
          4'd9:             cur_nib = 4'h6;
          4'd11:            cur_nib = 4'h1;
          default:          cur_nib = 4'h0;
        endcase
        nib_last = (nib_idx == INIT_LAST);
      end
      ADDR1: begin
        cur_nib  = nib_idx[0] ? 4'h0 : 4'h8;
        nib_last = (nib_idx == ADDR_LAST);
      end
      ADDR2: begin
        cur_nib  = nib_idx[0] ? 4'h0 : 4'hC;
        nib_last = (nib_idx == ADDR_LAST);
      end
      ROW1, ROW2: begin
        row_shift = ((state == ROW1) ? row1_buf : row2_buf) << {nib_idx[6:1], 3'b000};
        ch        = row_shift[8*NUM_COLS-1 -: 8];
        cur_nib   = nib_idx[0] ? ch[3:0] : ch[7:4];
        cur_rs    = 1'b1;
        nib_last  = (nib_idx == ROW_LAST);
      end
      default: begin
        cur_nib = 4'h0;
      end
    endcase
  end

  // Frame sequencer: walks init, clear wait, address and row writes one tick at a time
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 2'd0;
      nib_idx   <= '0;
      wait_cnt  <= '0;
      init_done <= 1'b0;
      row1_buf  <= '0;
      row2_buf  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      data      <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          phase    <= 2'd0;
          nib_idx  <= '0;
          wait_cnt <= '0;
          if ((state == FIN) && (CONTINUOUS != 0)) begin
            row1_buf <= line1;
            row2_buf <= line2;
            state    <= ADDR1;
          end else if (accept) begin
            row1_buf <= line1;
            row2_buf <= line2;
            busy     <= 1'b1;
            state    <= init_done ? ADDR1 : INIT;
          end else begin
            state <= IDLE;
          end
        end
        CLR_WAIT: begin
          if (tick) begin
            if (wait_cnt == WAIT_LAST) begin
              wait_cnt <= '0;
              state    <= ADDR1;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end
        end
        default: begin
          if (tick) begin
            case (phase)
              2'd0: begin
                lcd_rs <= cur_rs;
                data   <= cur_nib;
                lcd_e  <= 1'b0;
                phase  <= 2'd1;
              end
              2'd1: begin
                lcd_e <= 1'b1;
                phase <= 2'd2;
              end
              default: begin
                lcd_e <= 1'b0;
                phase <= 2'd0;
                if (!nib_last) begin
                  nib_idx <= nib_idx + 7'd1;
                end else begin
                  nib_idx <= '0;
                  case (state)
                    INIT: begin
                      init_done <= 1'b1;
                      if (CLEAR_WAIT > 0) state <= CLR_WAIT;
                      else                state <= ADDR1;
                    end
                    ADDR1: state <= ROW1;
                    ROW1: begin
                      if (NUM_ROWS == 2) begin
                        state <= ADDR2;
                      end else begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= (CONTINUOUS != 0);
                      end
                    end
                    ADDR2: state <= ROW2;
                    default: begin
                      state <= FIN;
                      done  <= 1'b1;
                      busy  <= (CONTINUOUS != 0);
                    end
                  endcase
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb_lcd_frame_writer: three small writer instances (two-row one-shot, one-row
// one-shot, two-row continuous) checked against an expected nibble stream and
// expected frame lengths.
module tb_lcd_frame_writer;

  localparam int DIV = 2;

  typedef struct packed {
    logic [1:0] dut;
    logic       rs;
    logic [3:0] nib;
  } nib_t;

  typedef struct {
    logic [15:0] l1;
    logic [15:0] l2;
    bit          with_init;
    int          ticks;
  } frame_vec_t;

  logic        clk = 1'b0;
  logic [2:0]  reset_s;
  logic [2:0]  start_s;
  logic [15:0] line1_s [3];
  logic [15:0] line2_s [3];
  logic [2:0]  busy_s;
  logic [2:0]  done_s;
  logic [2:0]  rs_s;
  logic [2:0]  w_s;
  logic [2:0]  e_s;
  logic [3:0]  data_s [3];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  nib_t exp_q [$];
  logic [2:0] e_prev = 3'b000;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  lcd_frame_writer #(.CLK_DIV(DIV), .NUM_COLS(2), .NUM_ROWS(2), .CLEAR_WAIT(1), .CONTINUOUS(0)) dut_a (
    .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .line1(line1_s[0]), .line2(line2_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .lcd_rs(rs_s[0]), .lcd_w(w_s[0]), .lcd_e(e_s[0]), .data(data_s[0]));

  lcd_frame_writer #(.CLK_DIV(DIV), .NUM_COLS(2), .NUM_ROWS(1), .CLEAR_WAIT(1), .CONTINUOUS(0)) dut_b (
    .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .line1(line1_s[1]), .line2(line2_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .lcd_rs(rs_s[1]), .lcd_w(w_s[1]), .lcd_e(e_s[1]), .data(data_s[1]));

  lcd_frame_writer #(.CLK_DIV(DIV), .NUM_COLS(2), .NUM_ROWS(2), .CLEAR_WAIT(1), .CONTINUOUS(1)) dut_c (
    .clk(clk), .reset(reset_s[2]), .start(start_s[2]), .line1(line1_s[2]), .line2(line2_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .lcd_rs(rs_s[2]), .lcd_w(w_s[2]), .lcd_e(e_s[2]), .data(data_s[2]));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void pushNib(input int d, input logic rs, input logic [3:0] n);
    nib_t e;
    e.dut = 2'(d);
    e.rs  = rs;
    e.nib = n;
    exp_q.push_back(e);
  endfunction

  function automatic void pushByte(input int d, input logic rs, input logic [7:0] b);
    pushNib(d, rs, b[7:4]);
    pushNib(d, rs, b[3:0]);
  endfunction

  // Expected nibble stream of one frame, built from the HD44780 command set
  function automatic void pushFrame(input int d, input bit with_init, input logic [15:0] l1,
                                    input logic [15:0] l2, input int rows);
    if (with_init) begin
      pushNib(d, 1'b0, 4'h3);
      pushNib(d, 1'b0, 4'h3);
      pushNib(d, 1'b0, 4'h3);
      pushNib(d, 1'b0, 4'h2);
      pushByte(d, 1'b0, 8'h28);
      pushByte(d, 1'b0, 8'h0C);
      pushByte(d, 1'b0, 8'h06);
      pushByte(d, 1'b0, 8'h01);
    end
    pushByte(d, 1'b0, 8'h80);
    pushByte(d, 1'b1, l1[15:8]);
    pushByte(d, 1'b1, l1[7:0]);
    if (rows == 2) begin
      pushByte(d, 1'b0, 8'hC0);
      pushByte(d, 1'b1, l2[15:8]);
      pushByte(d, 1'b1, l2[7:0]);
    end
  endfunction

  // Every rising enable edge consumes one expected nibble from the scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (e_s[d] && !e_prev[d]) begin
        if (exp_q.size() == 0) begin
          checkOutput($sformatf("dut%0d unexpected strobe", d), 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("dut%0d strobe {dut,rs,nib}", d),
                      {25'd0, 2'(d), rs_s[d], data_s[d]}, {25'd0, exp_q.pop_front()});
        end
      end
      e_prev[d] = e_s[d];
    end
  end

  // Loads the lines and pulses start (or leaves it high); returns at the negedge after acceptance
  task automatic applyStimulus(input int d, input logic [15:0] l1, input logic [15:0] l2,
                               input bit hold, output int t0);
    @(negedge clk);
    line1_s[d] = l1;
    line2_s[d] = l2;
    start_s[d] = 1'b1;
    @(negedge clk);
    if (!hold) start_s[d] = 1'b0;
    t0 = cyc;
    checkOutput($sformatf("dut%0d busy after accept", d), busy_s[d], 1'b1);
  endtask

  task automatic waitDone(input int d, input int limit, output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < limit) begin
      @(negedge clk);
      if (done_s[d]) begin
        at = cyc;
        break;
      end
      n++;
    end
    if (at < 0) checkOutput($sformatf("dut%0d done timeout", d), 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    frame_vec_t vecs [3];
    int t0;
    int at;
    int prev;
    int n;

    vecs[0] = '{l1: "AB", l2: "CD", with_init: 1'b1, ticks: 36 + 1 + 36};
    vecs[1] = '{l1: "Hi", l2: "!?", with_init: 1'b0, ticks: 36};
    vecs[2] = '{l1: "09", l2: "zz", with_init: 1'b0, ticks: 36};

    reset_s = 3'b111;
    start_s = 3'b000;
    for (int d = 0; d < 3; d++) begin
      line1_s[d] = 16'h0;
      line2_s[d] = 16'h0;
    end
    repeat (3) @(negedge clk);
    reset_s = 3'b000;
    @(negedge clk);
    checkOutput("reset busy", busy_s[0], 1'b0);
    checkOutput("reset done", done_s[0], 1'b0);
    checkOutput("reset lcd_rs", rs_s[0], 1'b0);
    checkOutput("reset lcd_w", w_s[0], 1'b0);
    checkOutput("reset lcd_e", e_s[0], 1'b0);
    checkOutput("reset data", data_s[0], 4'h0);

    $display("[TB] one-shot frames on the two-row writer");
    for (int i = 0; i < 3; i++) begin
      pushFrame(0, vecs[i].with_init, vecs[i].l1, vecs[i].l2, 2);
      applyStimulus(0, vecs[i].l1, vecs[i].l2, 1'b0, t0);
      waitDone(0, 400, at);
      checkOutput($sformatf("vec%0d frame cycles", i), at - t0, vecs[i].ticks * DIV);
      checkOutput($sformatf("vec%0d busy low with done", i), busy_s[0], 1'b0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d done one cycle", i), done_s[0], 1'b0);
      checkOutput($sformatf("vec%0d all nibbles seen", i), exp_q.size(), 0);
    end

    $display("[TB] start held high, line1 changed mid-frame");
    pushFrame(0, 1'b0, "PQ", "RS", 2);
    applyStimulus(0, "PQ", "RS", 1'b1, t0);
    repeat (4) @(negedge clk);
    line1_s[0] = "XY";
    waitDone(0, 400, at);
    start_s[0] = 1'b0;
    checkOutput("held start frame cycles", at - t0, 36 * DIV);
    repeat (20) @(negedge clk);
    checkOutput("held start no second frame", busy_s[0], 1'b0);
    checkOutput("held start nibbles consumed", exp_q.size(), 0);

    $display("[TB] reset during a row-1 strobe");
    pushFrame(0, 1'b0, "uv", "wx", 2);
    applyStimulus(0, "uv", "wx", 1'b0, t0);
    n = 0;
    while (n < 200 && !(e_s[0] && exp_q.size() == 9)) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("reached row-1 strobe", (n < 200), 1'b1);
    reset_s[0] = 1'b1;
    @(negedge clk);
    checkOutput("mid-frame reset lcd_e", e_s[0], 1'b0);
    checkOutput("mid-frame reset busy", busy_s[0], 1'b0);
    checkOutput("mid-frame reset data", data_s[0], 4'h0);
    checkOutput("mid-frame reset lcd_rs", rs_s[0], 1'b0);
    reset_s[0] = 1'b0;
    exp_q.delete();
    pushFrame(0, 1'b1, "AB", "CD", 2);
    applyStimulus(0, "AB", "CD", 1'b0, t0);
    waitDone(0, 400, at);
    checkOutput("post-reset frame reruns init", at - t0, 73 * DIV);
    checkOutput("post-reset nibbles consumed", exp_q.size(), 0);

    $display("[TB] start and reset together");
    @(negedge clk);
    start_s[0] = 1'b1;
    reset_s[0] = 1'b1;
    @(negedge clk);
    checkOutput("start+reset busy", busy_s[0], 1'b0);
    start_s[0] = 1'b0;
    reset_s[0] = 1'b0;

    $display("[TB] single-row writer");
    pushFrame(1, 1'b1, "AB", "CD", 1);
    applyStimulus(1, "AB", "CD", 1'b0, t0);
    waitDone(1, 400, at);
    checkOutput("one-row first frame cycles", at - t0, (36 + 1 + 18) * DIV);
    pushFrame(1, 1'b0, "EF", "GH", 1);
    applyStimulus(1, "EF", "GH", 1'b0, t0);
    waitDone(1, 400, at);
    checkOutput("one-row later frame cycles", at - t0, 18 * DIV);
    @(negedge clk);
    checkOutput("one-row nibbles consumed", exp_q.size(), 0);

    $display("[TB] continuous writer");
    pushFrame(2, 1'b1, "ef", "gh", 2);
    applyStimulus(2, "ef", "gh", 1'b0, t0);
    waitDone(2, 400, at);
    checkOutput("continuous first frame cycles", at - t0, 73 * DIV);
    checkOutput("continuous busy at done 1", busy_s[2], 1'b1);
    pushFrame(2, 1'b0, "ef", "gh", 2);
    prev = at;
    repeat (20) @(negedge clk);
    line1_s[2] = "MN";
    waitDone(2, 400, at);
    checkOutput("continuous period 1", at - prev, 36 * DIV);
    checkOutput("continuous busy at done 2", busy_s[2], 1'b1);
    pushFrame(2, 1'b0, "MN", "gh", 2);
    prev = at;
    waitDone(2, 400, at);
    checkOutput("continuous period 2", at - prev, 36 * DIV);
    reset_s[2] = 1'b1;
    checkOutput("continuous nibbles consumed", exp_q.size(), 0);
    @(negedge clk);
    reset_s[2] = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("continuous stopped by reset", busy_s[2], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
